edge_burst_detector: RTL and testbench

Multi-channel, parametrised edge-burst detector. Each channel watches one asynchronous input, opens a counting window on the first qualifying edge, and raises a flag when a programmable number of edges arrives within a programmable number of clock cycles. It sits between raw external status lines and the interrupt/status aggregation logic.

---
 rtl/edge_burst_pkg.sv | 16 +
 rtl/edge_burst_channel.sv | 144 ++++++++++++++
 rtl/edge_burst_detector.sv | 47 ++++
 tb/tb_edge_burst_detector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/edge_burst_pkg.sv
// Shared constants and types for the edge-burst detector.
package edge_burst_pkg;

  // Edge qualification encodings for edge_mode
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Per-channel window state
  typedef enum logic {
    IDLE,
    ARMED
  } state_e;

endpackage

// File: rtl/edge_burst_channel.sv
// One detector channel: synchroniser, edge detect, window FSM, counters, flag.
module edge_burst_channel
  import edge_burst_pkg::*;
#(
  parameter int unsigned WINDOW_W    = 8,
  parameter int unsigned COUNT_W     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sig_in,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic [COUNT_W-1:0]  threshold,
  input  logic [1:0]          edge_mode,
  input  logic                sticky,
  input  logic                flag_clr,
  output logic                flag,
  output logic                hit_pulse,
  output logic [COUNT_W-1:0]  edge_count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d_q;
  logic                   edge_det;
  state_e                 state_q, state_d;
  logic [WINDOW_W-1:0]    win_q, win_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d, cnt_next, cnt_inc;
  logic                   done_q, done_d;
  logic                   flag_q, flag_d;
  logic                   hit_q, hit, close;
  logic [WINDOW_W-1:0]    eff_win;
  logic [COUNT_W-1:0]     eff_thr;
  logic [WINDOW_W:0]      win_inc;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain plus the one-cycle delay used for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // Qualify the raw rise/fall events by the configured edge mode
  always_comb begin
    edge_det = 1'b0;
    case (edge_mode)
      EDGE_RISE: edge_det = s & ~s_d_q;
      EDGE_FALL: edge_det = ~s & s_d_q;
      EDGE_BOTH: edge_det = s ^ s_d_q;
      default:   edge_det = 1'b0;
    endcase
  end

  // Zero-valued configs behave as 1
  assign eff_win = (window_len == '0) ? WINDOW_W'(1) : window_len;
  assign eff_thr = (threshold == '0) ? COUNT_W'(1) : threshold;
  // Extra bit keeps the close compare safe if window_len shrinks mid-window
  assign win_inc = {1'b0, win_q} + (WINDOW_W + 1)'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);

  // Window FSM next-state, counters and hit detection
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    cnt_next = cnt_q;
    hit      = 1'b0;
    close    = 1'b0;
    case (state_q)
      IDLE: begin
        win_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        if (edge_det) begin
          hit = (eff_thr == COUNT_W'(1));
          // A one-cycle window opens and closes in the same cycle
          if (eff_win == WINDOW_W'(1)) begin
            close = 1'b1;
          end else begin
            state_d = ARMED;
            win_d   = WINDOW_W'(1);
            cnt_d   = COUNT_W'(1);
            done_d  = hit;
          end
        end
      end
      ARMED: begin
        cnt_next = edge_det ? cnt_inc : cnt_q;
        hit      = edge_det && !done_q && (cnt_next == eff_thr);
        if (win_inc >= {1'b0, eff_win}) begin
          close   = 1'b1;
          state_d = IDLE;
          win_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          win_d  = win_inc[WINDOW_W-1:0];
          cnt_d  = cnt_next;
          done_d = done_q | hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag next-state: clears first, set last so a hit always wins
  always_comb begin
    flag_d = flag_q;
    // IDLE term clears a non-sticky flag set by a hit in the closing cycle
    if (!sticky && (close || state_q == IDLE)) flag_d = 1'b0;
    if (flag_clr) flag_d = 1'b0;
    if (hit) flag_d = 1'b1;
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      hit_q   <= hit;
    end
  end

  assign flag       = flag_q;
  assign hit_pulse  = hit_q;
  assign edge_count = cnt_q;

endmodule

// File: rtl/edge_burst_detector.sv
// Multi-channel edge-burst detector: replicates the channel and aggregates outputs.
module edge_burst_detector
  import edge_burst_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WINDOW_W    = 8,
  parameter int unsigned COUNT_W     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         sig_in,
  input  logic [WINDOW_W-1:0]         window_len,
  input  logic [COUNT_W-1:0]          threshold,
  input  logic [1:0]                  edge_mode,
  input  logic                        sticky,
  input  logic [CHANNELS-1:0]         flag_clr,
  output logic [CHANNELS-1:0]         flag,
  output logic [CHANNELS-1:0]         hit_pulse,
  output logic                        any_flag,
  output logic [CHANNELS*COUNT_W-1:0] edge_count
);

  // One independent channel per input line
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_burst_channel #(
      .WINDOW_W   (WINDOW_W),
      .COUNT_W    (COUNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .sig_in    (sig_in[i]),
      .window_len(window_len),
      .threshold (threshold),
      .edge_mode (edge_mode),
      .sticky    (sticky),
      .flag_clr  (flag_clr[i]),
      .flag      (flag[i]),
      .hit_pulse (hit_pulse[i]),
      .edge_count(edge_count[i*COUNT_W +: COUNT_W])
    );
  end

  assign any_flag = |flag;

endmodule

// File: tb/tb_edge_burst_detector.sv
// Directed self-checking bench for edge_burst_detector (4 channels, 2-stage sync).
module tb_edge_burst_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  sig_in;
  logic [7:0]  window_len;
  logic [3:0]  threshold;
  logic [1:0]  edge_mode;
  logic        sticky;
  logic [3:0]  flag_clr;
  logic [3:0]  flag;
  logic [3:0]  hit_pulse;
  logic        any_flag;
  logic [15:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  edge_burst_detector #(
    .CHANNELS   (4),
    .WINDOW_W   (8),
    .COUNT_W    (4),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .window_len(window_len),
    .threshold (threshold),
    .edge_mode (edge_mode),
    .sticky    (sticky),
    .flag_clr  (flag_clr),
    .flag      (flag),
    .hit_pulse (hit_pulse),
    .any_flag  (any_flag),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive sig_in for one cycle, then land just after the next rising edge
  task automatic step(input logic [3:0] s);
    sig_in = s;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    sig_in     = 4'b0;
    window_len = 8'd5;
    threshold  = 4'd3;
    edge_mode  = 2'b01;
    sticky     = 1'b1;
    flag_clr   = 4'b0;
    tick();
    tick();
    chk("reset_flag", {28'b0, flag}, 32'h0);
    chk("reset_hit", {28'b0, hit_pulse}, 32'h0);
    chk("reset_any", {31'b0, any_flag}, 32'h0);
    chk("reset_count", {16'b0, edge_count}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Hit within window: ch0 edges at detected cycles 2,4,6 -> hit visible cycle 7
    step(4'b0001); step(4'b0000); step(4'b0001);
    chk("s1_cnt1", {16'b0, edge_count}, 32'h0001);
    step(4'b0000); step(4'b0001);
    chk("s1_cnt2", {16'b0, edge_count}, 32'h0002);
    chk("s1_nohit_early", {28'b0, hit_pulse}, 32'h0);
    step(4'b0000);
    chk("s1_nohit_c6", {28'b0, hit_pulse}, 32'h0);
    step(4'b0000);
    chk("s1_hit", {28'b0, hit_pulse}, 32'h1);
    chk("s1_flag", {28'b0, flag}, 32'h1);
    chk("s1_any", {31'b0, any_flag}, 32'h1);
    chk("s1_cnt_closed", {16'b0, edge_count}, 32'h0);
    step(4'b0000);
    chk("s1_hit_once", {28'b0, hit_pulse}, 32'h0);
    chk("s1_flag_hold", {28'b0, flag}, 32'h1);
    flag_clr = 4'b0001;
    step(4'b0000);
    flag_clr = 4'b0000;
    chk("s1_flag_clr", {28'b0, flag}, 32'h0);
    chk("s1_any_clr", {31'b0, any_flag}, 32'h0);

    // Window expiry: ch1 edges at detected cycles 2,4,8
    step(4'b0010); step(4'b0000); step(4'b0010);
    chk("s2_cnt1", {16'b0, edge_count}, 32'h0010);
    step(4'b0000); step(4'b0000);
    chk("s2_cnt2", {16'b0, edge_count}, 32'h0020);
    step(4'b0000);
    chk("s2_cnt2_last", {16'b0, edge_count}, 32'h0020);
    step(4'b0010);
    chk("s2_closed", {16'b0, edge_count}, 32'h0);
    chk("s2_nohit", {28'b0, hit_pulse}, 32'h0);
    step(4'b0000); step(4'b0000);
    chk("s2_reopen", {16'b0, edge_count}, 32'h0010);
    chk("s2_nohit2", {28'b0, hit_pulse}, 32'h0);
    chk("s2_noflag", {28'b0, flag}, 32'h0);
    repeat (6) step(4'b0000);

    // Both-edge mode, non-sticky: ch2 rise@2, fall@4, rise@5
    edge_mode = 2'b11;
    sticky    = 1'b0;
    step(4'b0100); step(4'b0100); step(4'b0000);
    chk("s3_cnt1", {16'b0, edge_count}, 32'h0100);
    step(4'b0100); step(4'b0100);
    chk("s3_cnt2", {16'b0, edge_count}, 32'h0200);
    step(4'b0100);
    chk("s3_hit", {28'b0, hit_pulse}, 32'h4);
    chk("s3_flag", {28'b0, flag}, 32'h4);
    chk("s3_cnt3", {16'b0, edge_count}, 32'h0300);
    step(4'b0100);
    chk("s3_flag_close", {28'b0, flag}, 32'h0);
    chk("s3_hit_once", {28'b0, hit_pulse}, 32'h0);
    chk("s3_cnt_closed", {16'b0, edge_count}, 32'h0);
    step(4'b0000);
    repeat (8) step(4'b0000);
    edge_mode = 2'b01;
    sticky    = 1'b1;

    // Set beats clear on ch3
    step(4'b1000); step(4'b0000); step(4'b1000); step(4'b0000); step(4'b1000); step(4'b0000);
    flag_clr = 4'b1000;
    step(4'b0000);
    flag_clr = 4'b0000;
    chk("s4_hit", {28'b0, hit_pulse}, 32'h8);
    chk("s4_set_wins", {28'b0, flag}, 32'h8);
    step(4'b0000);
    chk("s4_flag_hold", {28'b0, flag}, 32'h8);

    // Reset mid-window after two ch0 edges
    step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000); step(4'b0000);
    chk("s5_cnt_pre", {16'b0, edge_count}, 32'h0002);
    chk("s5_any_pre", {31'b0, any_flag}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_cnt", {16'b0, edge_count}, 32'h0);
    chk("s5_rst_flag", {28'b0, flag}, 32'h0);
    chk("s5_rst_any", {31'b0, any_flag}, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000); step(4'b0000);
    chk("s5_post_cnt", {16'b0, edge_count}, 32'h0002);
    chk("s5_post_nohit", {28'b0, hit_pulse}, 32'h0);
    step(4'b0000);
    chk("s5_post_nohit2", {28'b0, hit_pulse}, 32'h0);
    repeat (4) step(4'b0000);

    // threshold=0 acts as 1: first edge hits
    threshold = 4'd0;
    step(4'b0010); step(4'b0000); step(4'b0000);
    chk("s6_thr0_hit", {28'b0, hit_pulse}, 32'h2);
    chk("s6_thr0_cnt", {16'b0, edge_count}, 32'h0010);
    repeat (5) step(4'b0000);
    threshold = 4'd3;
    flag_clr  = 4'b1111;
    step(4'b0000);
    flag_clr  = 4'b0000;
    chk("s6_clr_all", {28'b0, flag}, 32'h0);

    // Shrinking window_len below win_cnt closes the window next cycle
    step(4'b0001); step(4'b0000); step(4'b0000);
    chk("s6_win_cnt1", {16'b0, edge_count}, 32'h0001);
    step(4'b0000); step(4'b0000);
    chk("s6_win_open", {16'b0, edge_count}, 32'h0001);
    window_len = 8'd2;
    step(4'b0000);
    chk("s6_win_shrink", {16'b0, edge_count}, 32'h0);
    window_len = 8'd5;
    step(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
